attn_inst_sequencer: RTL
========================

Name: attn_inst_sequencer

Overview:
- Generates the 17-bit `inst` word that drives `fullchip` through one complete Q·K job, with no hand sequencing.
- Job order: Qmem write → Kmem write → K load into the array → execute → ofifo-to-pmem writeback → pmem readout.
- Sits between the host/stream interface and `fullchip`; `mem_in` data passes around it, and it only gates acceptance via `in_ready`.

Parameters:
- col, 8, number of K rows written and loaded (dot-product units).
- gap_cycles, 10, idle cycles inserted after KLOAD and after EXEC (array/ofifo drain).
- addr_bw, 4, width of qkmem_add and pmem_add fields.

Ports:
- clk  in  1  clock; all logic rising-edge.
- reset  in  1  synchronous, active-low; reset==0 clears all state at the next edge.
- start  in  1  single-cycle job request, sampled only in IDLE.
- n_q  in  4  number of Q vectors (1..15), captured on accepted start.
- abort  in  1  synchronous job cancel.
- in_valid  in  1  host has the Q/K row on mem_in this cycle.
- in_ready  out  1  row accepted this cycle (write phases only).
- inst  out  17  {ofifo_rd, qkmem_add[3:0], pmem_add[3:0], execute, load, qmem_rd, qmem_wr, kmem_rd, kmem_wr, pmem_rd, pmem_wr}.
- busy  out  1  high in any state except IDLE.
- phase  out  4  current state encoding, for debug.
- out_valid  out  1  fullchip full_out holds a valid pmem row.
- done  out  1  one-cycle pulse at end of job.
- err  out  1  one-cycle pulse when start is rejected.

Behaviour:
- Reset:
  - inst=0, in_ready=0, busy=0, phase=IDLE(0), out_valid=0, done=0, err=0, all counters 0.
  - Reset asserted mid-job behaves like abort; reset has priority over abort and start.
- Registering:
  - inst and all outputs are registered.
  - Start accepted at edge t → first QWR inst appears after edge t.
  - in_ready is combinational from state and in_valid (in_ready = in_valid in QWR/KWR), so the host and fullchip see the same cycle.
- States, with cycle counter c restarting at 0 on entry to each state:
  - IDLE(0): inst=0. If start && n_q!=0, latch n_q and go to QWR. If start && n_q==0, pulse err and stay in IDLE.
  - QWR(1): qkmem_add=c.
    - Stall (in_valid=0): qmem_wr=0, c holds.
    - Accept (in_valid=1): qmem_wr=1, c advances.
    - After n_q accepts, go to KWR; qkmem_add returns to 0.
  - KWR(2): same handshake with kmem_wr; after col accepts, go to KLOAD.
  - KLOAD(3): col+3 cycles, load=1 throughout.
    - c=0: kmem_rd=0.
    - c=1..col+1: kmem_rd=1, qkmem_add=max(0,c-1).
    - c=col+2: kmem_rd=0, qkmem_add=0.
    - Then go to GAP1.
  - GAP1(4): gap_cycles cycles, inst=0, then go to EXEC.
  - EXEC(5): n_q+1 cycles, execute=1, qmem_rd=1, qkmem_add=c. The extra cycle covers SRAM read latency. Then go to GAP2.
  - GAP2(6): gap_cycles cycles, inst=0, then go to WB.
  - WB(7): n_q cycles, ofifo_rd=1, pmem_wr=1, pmem_add=c. Then go to PRD.
  - PRD(8): n_q+1 cycles, pmem_rd=1, pmem_add=c.
    - out_valid is high in the cycle after each PRD cycle with c<n_q, giving exactly n_q pulses.
    - Then go to DONE.
  - DONE(9): done=1 and inst=0 for one cycle, then IDLE.
- Address fields:
  - 4-bit; n_q=15 gives a max address of 15 (EXEC/PRD c=15); no wrap occurs in legal use.
  - col must be ≤ 15: KLOAD reaches address col.
- Start while busy: ignored, no err.
- abort (any non-IDLE state): next edge → inst=0, out_valid=0, IDLE, no done pulse. Memory contents are not cleared.
- abort and start in the same cycle while IDLE: abort wins, start is dropped.
- Only one control bit group is active per state; qmem_wr and kmem_wr are never both 1.

Test Plan:
- Full job, n_q=8, in_valid held 1 → QWR 8 cycles with addr 0..7, KWR 8 cycles, KLOAD 11 cycles (kmem_rd high 9 cycles), EXEC 9 cycles, WB 8 cycles, PRD 9 cycles; 8 out_valid pulses; done exactly once; total start-to-done latency checked against the formula.
- Backpressure: in_valid toggling 1,0,0,1… during QWR → qmem_wr only on accept cycles; qkmem_add holds across stalls; exactly n_q writes.
- Boundary counts: n_q=1 → EXEC 2 cycles (addr 0,1), 1 out_valid pulse. n_q=15 → max qkmem_add=15, no wrap.
- Rejected start: n_q=0 → err pulse, busy stays 0. Start during EXEC → ignored, job completes unchanged.
- abort at EXEC c=3 → inst=0 next cycle, phase=IDLE, no done. A new start afterwards runs a clean full job.
- reset=0 at KLOAD c=5 → all outputs at reset values next edge. Same-cycle reset+start → start ignored.

Source files
------------

// File: rtl/attn_inst_sequencer.sv
// Sequences fullchip through one Q.K job: Q write, K write, K load, execute,
// ofifo-to-pmem writeback and pmem readout, producing the inst word each cycle.
module attn_inst_sequencer #(
  parameter int col        = 8,
  parameter int gap_cycles = 10,
  parameter int addr_bw    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [3:0]           n_q,
  input  logic                 abort,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [2*addr_bw+8:0] inst,
  output logic                 busy,
  output logic [3:0]           phase,
  output logic                 out_valid,
  output logic                 done,
  output logic                 err
);

  localparam int IW = 2*addr_bw + 9;
  localparam int CW = 8;
  localparam logic [CW-1:0] ONE   = CW'(1);
  localparam logic [CW-1:0] COL_C = CW'(col);
  localparam logic [CW-1:0] GAP_C = CW'(gap_cycles);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_QWR   = 4'd1,
    S_KWR   = 4'd2,
    S_KLOAD = 4'd3,
    S_GAP1  = 4'd4,
    S_EXEC  = 4'd5,
    S_GAP2  = 4'd6,
    S_WB    = 4'd7,
    S_PRD   = 4'd8,
    S_DONE  = 4'd9
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      nq_q, nq_d;
  logic [CW-1:0]   nq_w;
  logic [IW-1:0]   inst_q;
  logic            busy_q, done_q, err_q, err_d, ov_q, ov_d;
  logic [CW-1:0]   last_c;
  state_t          nxt_s;
  logic            adv;
  logic            qwr, kwr;

  assign nq_w = CW'(nq_q);

  // Control bits for a given state/counter; write enables are excluded because
  // they follow in_valid in the same cycle and are merged in combinationally.
  function automatic logic [IW-1:0] decode(input state_t s, input logic [CW-1:0] c);
    logic               ofifo_rd, execute, load, qmem_rd, kmem_rd, pmem_rd, pmem_wr;
    logic [addr_bw-1:0] qk, pa;
    ofifo_rd = 1'b0; execute = 1'b0; load = 1'b0; qmem_rd = 1'b0;
    kmem_rd  = 1'b0; pmem_rd = 1'b0; pmem_wr = 1'b0;
    qk = '0;
    pa = '0;
    case (s)
      S_QWR, S_KWR: qk = addr_bw'(c);
      S_KLOAD: begin
        load = 1'b1;
        if (c >= ONE && c <= COL_C + ONE) begin
          kmem_rd = 1'b1;
          qk      = addr_bw'(c - ONE);
        end
      end
      S_EXEC: begin
        execute = 1'b1;
        qmem_rd = 1'b1;
        qk      = addr_bw'(c);
      end
      S_WB: begin
        ofifo_rd = 1'b1;
        pmem_wr  = 1'b1;
        pa       = addr_bw'(c);
      end
      S_PRD: begin
        pmem_rd = 1'b1;
        pa      = addr_bw'(c);
      end
      default: ;
    endcase
    return {ofifo_rd, qk, pa, execute, load, qmem_rd, 1'b0, kmem_rd, 1'b0, pmem_rd, pmem_wr};
  endfunction

  // Next-state: each state runs its counter up to last_c, then moves to nxt_s.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    nq_d    = nq_q;
    err_d   = 1'b0;
    last_c  = '0;
    nxt_s   = S_IDLE;
    adv     = 1'b1;
    case (state_q)
      S_IDLE:  adv = 1'b0;
      S_QWR:   begin last_c = nq_w - ONE;   nxt_s = S_KWR;   adv = in_valid; end
      S_KWR:   begin last_c = COL_C - ONE;  nxt_s = S_KLOAD; adv = in_valid; end
      S_KLOAD: begin last_c = COL_C + CW'(2); nxt_s = S_GAP1; end
      S_GAP1:  begin last_c = GAP_C - ONE;  nxt_s = S_EXEC;  end
      S_EXEC:  begin last_c = nq_w;         nxt_s = S_GAP2;  end
      S_GAP2:  begin last_c = GAP_C - ONE;  nxt_s = S_WB;    end
      S_WB:    begin last_c = nq_w - ONE;   nxt_s = S_PRD;   end
      S_PRD:   begin last_c = nq_w;         nxt_s = S_DONE;  end
      S_DONE:  begin last_c = '0;           nxt_s = S_IDLE;  end
      default: begin adv = 1'b0; state_d = S_IDLE; end
    endcase

    if (state_q == S_IDLE) begin
      if (start && !abort) begin
        if (n_q != 4'd0) begin
          state_d = S_QWR;
          nq_d    = n_q;
          cnt_d   = '0;
        end else begin
          err_d = 1'b1;
        end
      end
    end else if (adv) begin
      if (cnt_q == last_c) begin
        state_d = nxt_s;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_q + ONE;
      end
    end

    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  assign ov_d = (state_q == S_PRD) && (cnt_q < nq_w) && !abort;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      nq_q    <= '0;
      inst_q  <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      nq_q    <= nq_d;
      inst_q  <= decode(state_d, cnt_d);
      busy_q  <= (state_d != S_IDLE);
      done_q  <= (state_d == S_DONE);
      err_q   <= err_d;
      ov_q    <= ov_d;
    end
  end

  assign qwr       = in_valid && (state_q == S_QWR);
  assign kwr       = in_valid && (state_q == S_KWR);
  assign in_ready  = qwr || kwr;
  assign inst      = inst_q | {{(IW-5){1'b0}}, qwr, 1'b0, kwr, 2'b00};
  assign busy      = busy_q;
  assign phase     = state_q;
  assign out_valid = ov_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule
